pipeline_trace_buffer: RTL and testbench

Synthesizable instruction-trace capture unit for the 3-stage pipelined core. It replaces per-cycle simulation printouts of decode-stage PC/instruction and stall status with a hardware circular buffer, configurable in depth and width, with wrap, stop-on-full and PC-trigger modes. It also keeps cycle and stall counters. It sits beside riscv_pipelined_top, is fed from the decode-stage signals, and is drained through a valid/ready read port by a debug host or testbench.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_ring_mem.sv | 65 ++++++
 rtl/pipeline_trace_buffer.sv | 145 ++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the decode-stage trace buffer.
// Entry fields are sized by TRACE_DW; a core with wider PCs needs TRACE_DW raised.
package trace_pkg;

  localparam int TRACE_DW = 32;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_WRAP      = 2'b01,
    MODE_STOP_FULL = 2'b10,
    MODE_TRIGGER   = 2'b11
  } trace_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_POST    = 2'b10,
    ST_DONE    = 2'b11
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_DW-1:0] pc;
    logic [TRACE_DW-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_mem.sv
// Circular entry store: synchronous write, asynchronous read of the oldest entry.
// A write when full overwrites the oldest entry; pops on an empty store are ignored.
module trace_ring_mem
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  trace_entry_t wr_entry_i,
  input  logic         rd_pop_i,
  output trace_entry_t rd_entry_o,
  output logic [PTRW:0] count_o
);

  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

  trace_entry_t      r_mem [DEPTH];
  logic [PTRW-1:0]   r_wr_ptr;
  logic [PTRW-1:0]   r_rd_ptr;
  logic [PTRW:0]     r_count;
  logic              w_full;
  logic              w_pop;

  assign w_full = (r_count == FULL);
  assign w_pop  = rd_pop_i && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i) begin
      r_mem[r_wr_ptr] <= wr_entry_i;
    end
  end

  // Pointers are power-of-two wide, so natural overflow gives modulo-DEPTH wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en_i) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop || (wr_en_i && w_full)) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (wr_en_i && !w_pop && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !wr_en_i) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign rd_entry_o = r_mem[r_rd_ptr];
  assign count_o    = r_count;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Decode-stage instruction trace capture with wrap, stop-on-full and PC-trigger modes.
// Captures are readable one cycle after DONE; the read port pops only on valid & ready.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 16,
  parameter  int CNTW  = 32,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cap_valid_i,
  input  logic [DW-1:0]   pc_i,
  input  logic [DW-1:0]   instr_i,
  input  logic            stall_fd_i,
  input  logic            stall_mw_i,
  input  logic [1:0]      mode_i,
  input  logic [DW-1:0]   trig_pc_i,
  input  logic [PTRW:0]   post_cnt_i,
  input  logic            arm_i,
  input  logic            stop_i,
  input  logic            rd_ready_i,
  output logic            rd_valid_o,
  output logic [DW-1:0]   rd_pc_o,
  output logic [DW-1:0]   rd_instr_o,
  output logic [1:0]      state_o,
  output logic [PTRW:0]   count_o,
  output logic            triggered_o,
  output logic [CNTW-1:0] cycle_cnt_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam logic [PTRW:0] LAST_SLOT = (PTRW+1)'(DEPTH - 1);
  localparam logic [PTRW:0] ONE_LEFT  = (PTRW+1)'(1);

  trace_state_e    r_state;
  trace_mode_e     r_mode;
  logic [PTRW:0]   r_post_len;
  logic [PTRW:0]   r_post_left;
  logic            r_triggered;
  logic [CNTW-1:0] r_cycle_cnt;
  logic [CNTW-1:0] r_stall_cnt;

  trace_state_e    w_next_state;
  logic            w_active;
  logic            w_cap;
  logic            w_arm_go;
  logic            w_trig_hit;
  logic            w_pop;
  logic [PTRW:0]   w_count;
  trace_entry_t    w_wr_entry;
  trace_entry_t    w_rd_entry;

  assign w_active   = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_cap      = cap_valid_i && w_active && !arm_i;
  assign w_arm_go   = arm_i && (mode_i != MODE_OFF);
  assign w_trig_hit = w_cap && (r_state == ST_CAPTURE) && (r_mode == MODE_TRIGGER)
                      && (pc_i == trig_pc_i);
  assign w_pop      = (r_state == ST_DONE) && rd_ready_i;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_CAPTURE: begin
        if (stop_i) begin
          w_next_state = ST_DONE;
        end else if (r_mode == MODE_STOP_FULL) begin
          if (w_cap && (w_count == LAST_SLOT)) w_next_state = ST_DONE;
        end else if (w_trig_hit) begin
          w_next_state = (r_post_len == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (stop_i || (w_cap && (r_post_left == ONE_LEFT))) w_next_state = ST_DONE;
      end
      default: ;
    endcase
    if (arm_i) begin
      w_next_state = w_arm_go ? ST_CAPTURE : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_OFF;
      r_post_len  <= '0;
      r_post_left <= '0;
      r_triggered <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_arm_go) begin
        r_mode      <= trace_mode_e'(mode_i);
        r_post_len  <= post_cnt_i;
        r_post_left <= '0;
        r_triggered <= 1'b0;
        r_cycle_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (w_trig_hit) begin
          r_triggered <= 1'b1;
          r_post_left <= r_post_len;
        end else if ((r_state == ST_POST) && w_cap) begin
          r_post_left <= r_post_left - 1'b1;
        end
        // Counters saturate rather than wrap so long captures stay meaningful.
        if (w_active) begin
          if (r_cycle_cnt != {CNTW{1'b1}}) r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if ((stall_fd_i || stall_mw_i) && (r_stall_cnt != {CNTW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign w_wr_entry.pc    = TRACE_DW'(pc_i);
  assign w_wr_entry.instr = TRACE_DW'(instr_i);

  trace_ring_mem #(
    .DEPTH      (DEPTH)
  ) u_ring (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_arm_go),
    .wr_en_i    (w_cap),
    .wr_entry_i (w_wr_entry),
    .rd_pop_i   (w_pop),
    .rd_entry_o (w_rd_entry),
    .count_o    (w_count)
  );

  assign rd_valid_o  = (r_state == ST_DONE) && (w_count != '0);
  assign rd_pc_o     = w_rd_entry.pc[DW-1:0];
  assign rd_instr_o  = w_rd_entry.instr[DW-1:0];
  assign state_o     = r_state;
  assign count_o     = w_count;
  assign triggered_o = r_triggered;
  assign cycle_cnt_o = r_cycle_cnt;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_pipeline_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNTW  = 8;
  localparam int PTRW  = 4;
  localparam int CMAX  = 255;

  logic            clk;
  logic            rst;
  logic            cap_valid;
  logic [DW-1:0]   pc;
  logic [DW-1:0]   instr;
  logic            stall_fd;
  logic            stall_mw;
  logic [1:0]      mode;
  logic [DW-1:0]   trig_pc;
  logic [PTRW:0]   post_cnt;
  logic            arm;
  logic            stop;
  logic            rd_ready;
  logic            rd_valid;
  logic [DW-1:0]   rd_pc;
  logic [DW-1:0]   rd_instr;
  logic [1:0]      state;
  logic [PTRW:0]   count;
  logic            triggered;
  logic [CNTW-1:0] cycle_cnt;
  logic [CNTW-1:0] stall_cnt;

  pipeline_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cap_valid_i (cap_valid),
    .pc_i        (pc),
    .instr_i     (instr),
    .stall_fd_i  (stall_fd),
    .stall_mw_i  (stall_mw),
    .mode_i      (mode),
    .trig_pc_i   (trig_pc),
    .post_cnt_i  (post_cnt),
    .arm_i       (arm),
    .stop_i      (stop),
    .rd_ready_i  (rd_ready),
    .rd_valid_o  (rd_valid),
    .rd_pc_o     (rd_pc),
    .rd_instr_o  (rd_instr),
    .state_o     (state),
    .count_o     (count),
    .triggered_o (triggered),
    .cycle_cnt_o (cycle_cnt),
    .stall_cnt_o (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t m_q[$];
  int   m_state;
  int   m_mode;
  int   m_post;
  int   m_left;
  int   m_trig;
  int   m_cyc;
  int   m_stl;

  int   n_checks;
  int   n_pass;

  function automatic logic [DW-1:0] ins_of(input logic [DW-1:0] p);
    return {p[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_mode = 0; m_post = 0; m_left = 0;
    m_trig = 0; m_cyc = 0; m_stl = 0;
  endtask

  // Applies the behavioural rules for one clock edge, using the inputs as driven now.
  task automatic model_step();
    bit   active, cap, pop, hit;
    ent_t e;
    active = (m_state == 1) || (m_state == 2);
    cap    = cap_valid && active && !arm;
    pop    = (m_state == 3) && (m_q.size() > 0) && rd_ready;
    if (active) begin
      if (m_cyc < CMAX) m_cyc++;
      if ((stall_fd || stall_mw) && m_stl < CMAX) m_stl++;
    end
    if (arm) begin
      if (mode != 2'b00) begin
        m_q.delete();
        m_cyc = 0; m_stl = 0; m_trig = 0; m_left = 0;
        m_mode = int'(mode); m_post = int'(post_cnt);
        m_state = 1;
      end else begin
        m_state = 0;
      end
      return;
    end
    if (cap) begin
      e.pc = pc; e.instr = instr;
      m_q.push_back(e);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
    end
    if (pop) void'(m_q.pop_front());
    if (m_state == 1) begin
      hit = (m_mode == 3) && cap && (pc == trig_pc);
      if (hit) begin m_trig = 1; m_left = m_post; end
      if (stop) m_state = 3;
      else if (m_mode == 2 && m_q.size() == DEPTH) m_state = 3;
      else if (hit) m_state = (m_post == 0) ? 3 : 2;
    end else if (m_state == 2) begin
      if (cap) m_left--;
      if (stop || m_left == 0) m_state = 3;
    end
  endtask

  task automatic check_all();
    bit exp_valid;
    exp_valid = (m_state == 3) && (m_q.size() > 0);
    chk("state",     64'(state),     64'(m_state));
    chk("count",     64'(count),     64'(m_q.size()));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stl));
    chk("rd_valid",  64'(rd_valid),  64'(exp_valid));
    if (exp_valid) begin
      chk("rd_pc",    64'(rd_pc),    64'(m_q[0].pc));
      chk("rd_instr", 64'(rd_instr), 64'(m_q[0].instr));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic arm_mode(input logic [1:0] md, input logic [DW-1:0] tpc, input logic [PTRW:0] pcnt);
    mode = md; trig_pc = tpc; post_cnt = pcnt; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      cap_valid = 1'b1;
      pc = base + DW'(4 * i);
      instr = ins_of(pc);
      tick();
    end
    cap_valid = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain_expect(input logic [DW-1:0] first, input int n, input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk(tag, 64'(rd_pc), 64'(first + DW'(4 * i)));
      tick();
    end
    chk({tag, "_empty"}, 64'(rd_valid), 64'(0));
    rd_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; cap_valid = 1'b0; pc = '0; instr = '0;
    stall_fd = 1'b0; stall_mw = 1'b0; mode = 2'b00; trig_pc = '0;
    post_cnt = '0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Arm with mode off, stop while idle: both leave IDLE untouched.
    arm_mode(2'b00, '0, '0);
    stop_pulse();
    chk("idle_hold", 64'(state), 64'(0));

    // Asynchronous reset in the middle of a capture.
    arm_mode(2'b01, '0, '0);
    stall_fd = 1'b1;
    feed(5, 32'h100);
    stall_fd = 1'b0;
    chk("pre_rst_count", 64'(count), 64'(5));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_cycle", 64'(cycle_cnt), 64'(0));
    #2 rst = 1'b0;

    // Wrap: 20 captures keep the newest 16.
    arm_mode(2'b01, '0, '0);
    feed(20, 32'd0);
    stop_pulse();
    chk("wrap_count", 64'(count), 64'(16));
    drain_expect(32'd16, 16, "wrap_pc");

    // Stop-when-full: DONE on the 16th capture, 17th dropped.
    arm_mode(2'b10, '0, '0);
    feed(16, 32'd0);
    chk("full_state", 64'(state), 64'(3));
    feed(1, 32'h3E0);
    chk("full_count", 64'(count), 64'(16));
    drain_expect(32'd0, 16, "full_pc");

    // Trigger with three post-trigger entries.
    arm_mode(2'b11, 32'd40, 5'd3);
    feed(26, 32'd0);
    chk("trig_flag", 64'(triggered), 64'(1));
    chk("trig_count", 64'(count), 64'(14));
    drain_expect(32'd0, 14, "trig_pc");

    // Trigger with no post-trigger entries.
    arm_mode(2'b11, 32'd40, 5'd0);
    feed(26, 32'd0);
    chk("trig0_count", 64'(count), 64'(11));
    drain_expect(32'd0, 11, "trig0_pc");

    // Counters: 10 capture cycles, stalls on 4 distinct cycles, 8 captures.
    arm_mode(2'b01, '0, '0);
    for (int i = 0; i < 10; i++) begin
      cap_valid = (i < 8);
      pc = DW'(4 * i);
      instr = ins_of(pc);
      stall_fd = (i < 3);
      stall_mw = (i == 2) || (i == 3);
      stop = (i == 9);
      tick();
    end
    cap_valid = 1'b0; stall_fd = 1'b0; stall_mw = 1'b0; stop = 1'b0;
    chk("cnt_cycle", 64'(cycle_cnt), 64'(10));
    chk("cnt_stall", 64'(stall_cnt), 64'(4));

    // Reader stalls: nothing pops, data holds.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", 64'(rd_pc), 64'(0));
      chk("hold_count", 64'(count), 64'(8));
    end

    // Arm and stop together: arm wins.
    stop = 1'b1;
    arm_mode(2'b01, '0, '0);
    stop = 1'b0;
    chk("restart_state", 64'(state), 64'(1));
    chk("restart_count", 64'(count), 64'(0));

    // Saturation of both counters on a long capture.
    stall_mw = 1'b1;
    feed(300, 32'd0);
    stall_mw = 1'b0;
    stop_pulse();
    chk("sat_cycle", 64'(cycle_cnt), 64'(255));
    chk("sat_stall", 64'(stall_cnt), 64'(255));
    drain_expect(32'd1136, 16, "sat_pc");

    // Arm with mode off from DONE returns to IDLE.
    arm_mode(2'b00, '0, '0);
    chk("off_state", 64'(state), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
